// File: rtl/fib_pkg.sv
// Shared constants, FSM state type and the Fibonacci step function used by the
// byte serializer and its recurrence checker.
package fib_pkg;

    localparam int FIB_W          = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    // Next Fibonacci term; the carry out of the top bit is dropped on purpose.
    function automatic logic [FIB_W-1:0] fib_next(
        input logic [FIB_W-1:0] a,
        input logic [FIB_W-1:0] b
    );
        return a + b;
    endfunction

endpackage

// File: rtl/fib_fifo.sv
// Synchronous word FIFO with a first-word view of the head entry. A pop on an
// empty FIFO and a push on a full FIFO are ignored, so a push into an empty FIFO
// is only visible to pops from the following cycle onward.
module fib_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write.
    // NOTE: the data array has no reset; the pointers and count alone decide
    // what is valid, and leaving the array unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fib_byte_serializer.sv
// Buffers incoming 32-bit Fibonacci words, streams each one out MSB byte first
// on a byte-wide valid/ready link, and flags any break in the recurrence.
module fib_byte_serializer
    import fib_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FIB_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic             out_last,
    output logic             seq_err,
    output logic [AW:0]      fifo_level
);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [FIB_W-1:0] r_word;
    logic             r_out_valid;
    logic             r_out_last;
    logic [FIB_W-1:0] r_prev1;
    logic [FIB_W-1:0] r_prev2;
    logic [1:0]       r_hist_cnt;
    logic             r_seq_err;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [FIB_W-1:0] w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_out_hs;

    assign in_ready   = !w_fifo_full;
    assign w_push     = in_valid && !w_fifo_full;
    assign w_out_hs   = r_out_valid && out_ready;
    // Pop when idle, or on the final byte so the next word follows with no bubble.
    assign w_pop      = !w_fifo_empty &&
                        ((r_state == S_IDLE) || (w_out_hs && (r_idx == '0)));

    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    // The word is shifted left after each byte, so the current byte is always on top.
    assign out_byte   = r_word[FIB_W-1 -: BYTE_W];
    assign seq_err    = r_seq_err;

    fib_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIB_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    // Serializer FSM: loads a word from the FIFO and walks its bytes MSB first.
    // NOTE: all state here uses non-blocking assignments so every branch reads
    // the pre-edge values of r_idx/r_word, matching the combinational w_pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_word      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_word      <= w_head;
                        r_idx       <= IDX_W'(BYTES_PER_WORD - 1);
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_out_hs) begin
                        if (r_idx != '0) begin
                            r_word     <= r_word << BYTE_W;
                            r_idx      <= r_idx - IDX_W'(1);
                            r_out_last <= (r_idx == IDX_W'(1));
                        end else if (!w_fifo_empty) begin
                            r_word     <= w_head;
                            r_idx      <= IDX_W'(BYTES_PER_WORD - 1);
                            r_out_last <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Recurrence checker: history advances only on accepted words; error is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev1    <= '0;
            r_prev2    <= '0;
            r_hist_cnt <= '0;
            r_seq_err  <= 1'b0;
        end else if (w_push) begin
            if ((r_hist_cnt == 2'd2) && (in_data != fib_next(r_prev1, r_prev2))) begin
                r_seq_err <= 1'b1;
            end
            r_prev2 <= r_prev1;
            r_prev1 <= in_data;
            if (r_hist_cnt != 2'd2) begin
                r_hist_cnt <= r_hist_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fib_byte_serializer.sv
// Directed bench for fib_byte_serializer: every accepted word queues its four
// expected bytes, and every byte handshake pops and compares one entry.
module tb_fib_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        seq_err;
    logic [2:0]  fifo_level;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          bubbles  = 0;
    bit          track    = 1'b0;
    bit          prev_hs  = 1'b0;
    bit          acc      = 1'b0;
    logic [8:0]  sb [$];

    fib_byte_serializer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .seq_err    (seq_err),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample both handshakes at the falling edge, then advance past the rising edge.
    task automatic step();
        logic [8:0] exp;
        @(negedge clk);
        if (track && prev_hs && !out_valid && sb.size() != 0) bubbles++;
        prev_hs = out_valid && out_ready;
        if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("out_byte", 32'(out_byte), 32'(exp[7:0]));
                check("out_last", 32'(out_last), 32'(exp[8]));
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            for (int b = 3; b >= 0; b--) sb.push_back({(b == 0), in_data[8*b +: 8]});
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = acc;
        end
        check("accept", 32'(got), 32'd1);
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        check(tag, 32'(sb.size()), 32'd0);
        step();
        check("idle_after_drain", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        prev_hs  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_byte",   32'(out_byte),   32'd0);
        check("rst_out_last",   32'(out_last),   32'd0);
        check("rst_seq_err",    32'(seq_err),    32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);

        // Streaming 0,1,1,2,3 with one-cycle latency and no inter-word bubbles.
        out_ready = 1'b1;
        track     = 1'b1;
        bubbles   = 0;
        send(32'd0);
        send(32'd1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_byte",  32'(out_byte),  32'h00);
        send(32'd1);
        send(32'd2);
        send(32'd3);
        drain("drain_stream");
        track = 1'b0;
        check("no_bubble",      32'(bubbles), 32'd0);
        check("seq_err_stream", 32'(seq_err), 32'd0);

        // Backpressure: DEPTH+1 words fit, then in_ready drops and output holds.
        out_ready = 1'b0;
        n_acc     = 0;
        send(32'd5);
        send(32'd8);
        send(32'd13);
        send(32'd21);
        send(32'd34);
        in_data = 32'd55;
        check("bp_in_ready",  32'(in_ready),   32'd0);
        check("bp_level",     32'(fifo_level), 32'd4);
        check("bp_valid",     32'(out_valid),  32'd1);
        check("bp_byte",      32'(out_byte),   32'h00);
        check("bp_last",      32'(out_last),   32'd0);
        repeat (3) step();
        check("bp_hold_level", 32'(fifo_level), 32'd4);
        check("bp_hold_valid", 32'(out_valid),  32'd1);
        check("bp_hold_byte",  32'(out_byte),   32'h00);
        check("bp_acc_full",   32'(n_acc),      32'd5);
        out_ready = 1'b1;
        send(32'd55);
        check("bp_acc_total", 32'(n_acc), 32'd6);
        drain("drain_bp");
        check("seq_err_bp", 32'(seq_err), 32'd0);

        // Bad recurrence 1,2,4 then correct 6,10: error rises on 4 and sticks.
        do_reset();
        out_ready = 1'b1;
        send(32'd1);
        send(32'd2);
        check("bad_before", 32'(seq_err), 32'd0);
        send(32'd4);
        check("bad_on_4", 32'(seq_err), 32'd1);
        send(32'd6);
        send(32'd10);
        drain("drain_bad");
        check("bad_sticky", 32'(seq_err), 32'd1);

        // 32-bit wrap-around is a valid recurrence.
        do_reset();
        out_ready = 1'b1;
        send(32'h8000_0000);
        send(32'h8000_0000);
        send(32'h0000_0000);
        send(32'h8000_0000);
        drain("drain_wrap");
        check("wrap_seq_err", 32'(seq_err), 32'd0);

        // Mid-word reset aborts output, drops FIFO contents and clears history.
        do_reset();
        out_ready = 1'b1;
        send(32'h1122_3344);
        send(32'h5566_7788);
        in_valid = 1'b0;
        step();
        check("mid_byte",  32'(out_byte),   32'h22);
        check("mid_level", 32'(fifo_level), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid),  32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_ready", 32'(in_ready),   32'd1);
        sb.delete();
        prev_hs = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        send(32'd7);
        send(32'd9);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_byte",  32'(out_byte),  32'h00);
        drain("drain_post_rst");
        check("post_rst_seq_err", 32'(seq_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
